// File: rtl/tx_pkg.sv
// rtl/tx_pkg.sv - shared state type, packet geometry and header byte helper for the packetizer
package tx_pkg;
    localparam int PIX_PER_PKT = 32;
    localparam int DATA_LAT    = 6;
    localparam int HDR_LEN     = 4;
    localparam int PAY_BYTES   = PIX_PER_PKT * 3 / 2;
    localparam int LAT_W       = $clog2(DATA_LAT + 1);
    localparam logic [7:0] LEN_BYTE = 8'(3 + PAY_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_WAITPIX,
        ST_PACK,
        ST_WAITDONE
    } tx_state_e;

    function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic frm,
                                            input logic [6:0] seq, input logic [15:0] add);
        case (idx)
            2'd0:    return LEN_BYTE;
            2'd1:    return {frm, seq};
            2'd2:    return add[15:8];
            default: return add[7:0];
        endcase
    endfunction
endpackage

// File: rtl/tx_packetizer_if.sv
// rtl/tx_packetizer_if.sv - byte stream from the packetizer to the radio TX FIFO writer
interface tx_packetizer_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/tx_byte_reg.sv
// rtl/tx_byte_reg.sv - one-entry hold register driving the outgoing byte stream
module tx_byte_reg (
    input  logic       Cclk,
    input  logic       rstn,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    tx_packetizer_if.master tx
);
    // A new byte may enter when the slot is empty or its occupant leaves this cycle.
    assign in_ready = !tx.tvalid || tx.tready;

    always_ff @(posedge Cclk or negedge rstn) begin
        if (!rstn) begin
            tx.tvalid <= 1'b0;
            tx.tdata  <= 8'h00;
            tx.tlast  <= 1'b0;
        end else if (in_valid && in_ready) begin
            tx.tvalid <= 1'b1;
            tx.tdata  <= in_data;
            tx.tlast  <= in_last;
        end else if (tx.tready) begin
            tx.tvalid <= 1'b0;
            tx.tlast  <= 1'b0;
        end
    end
endmodule

// File: rtl/tx_packetizer.sv
// rtl/tx_packetizer.sv - packs the 12-bit pixel stream into headered radio packets paced by tx_done
module tx_packetizer
    import tx_pkg::*;
(
    input  logic        Cclk,
    input  logic        rstn,
    input  logic        TranEn,
    input  logic [11:0] TranData,
    input  logic        TranFrame,
    input  logic [15:0] TranAdd,
    output logic        NextData,
    tx_packetizer_if.master tx,
    input  logic        tx_done,
    output logic        busy,
    output logic [10:0] pkt_cnt
);
    tx_state_e        state, state_n;
    logic [1:0]       byte_idx;
    logic [LAT_W-1:0] lat_cnt;
    logic [5:0]       pix_cnt;
    logic             odd_pix, en_lost, hdr_frm;
    logic [15:0]      hdr_add;
    logic [6:0]       seq;
    logic [11:0]      pix_a, pix_b, pix_val;
    logic             push, push_last, in_ready, start, sample, done_ok, lat_done, final_pix;
    logic [7:0]       push_data;

    assign lat_done  = lat_cnt == LAT_W'(DATA_LAT - 1);
    assign final_pix = pix_cnt == 6'(PIX_PER_PKT);
    // The final byte must have left before tx_done can close the packet.
    assign done_ok   = (state == ST_WAITDONE) && tx_done && !tx.tvalid;
    assign pix_val   = NextData ? TranData : 12'h000;
    assign busy      = state != ST_IDLE;

    always_ff @(posedge Cclk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        push      = 1'b0;
        push_data = 8'h00;
        push_last = 1'b0;
        start     = 1'b0;
        sample    = 1'b0;
        NextData  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (TranEn) begin
                    start   = 1'b1;
                    state_n = ST_HDR;
                end
            end
            ST_HDR: begin
                if (in_ready) begin
                    push      = 1'b1;
                    push_data = hdr_byte(byte_idx, hdr_frm, seq, hdr_add);
                    if (byte_idx == 2'(HDR_LEN - 1)) state_n = ST_WAITPIX;
                end
            end
            ST_WAITPIX: begin
                // Once the window has closed, pixels are padded with zeros and memory is left alone.
                if (lat_done && in_ready) begin
                    sample   = 1'b1;
                    NextData = TranEn && !en_lost;
                    if (odd_pix) state_n = ST_PACK;
                end
            end
            ST_PACK: begin
                if (in_ready) begin
                    push = 1'b1;
                    case (byte_idx)
                        2'd0:    push_data = pix_a[11:4];
                        2'd1:    push_data = {pix_a[3:0], pix_b[11:8]};
                        default: push_data = pix_b[7:0];
                    endcase
                    if (byte_idx == 2'd2) begin
                        push_last = final_pix;
                        state_n   = final_pix ? ST_WAITDONE : ST_WAITPIX;
                    end
                end
            end
            ST_WAITDONE: begin
                if (done_ok) begin
                    start   = TranEn;
                    state_n = TranEn ? ST_HDR : ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (start) begin
            push      = 1'b1;
            push_data = LEN_BYTE;
        end
    end

    always_ff @(posedge Cclk or negedge rstn) begin
        if (!rstn) begin
            byte_idx <= 2'd0;
            lat_cnt  <= '0;
            pix_cnt  <= 6'd0;
            odd_pix  <= 1'b0;
            en_lost  <= 1'b0;
            hdr_frm  <= 1'b0;
            hdr_add  <= 16'h0000;
            seq      <= 7'd0;
            pkt_cnt  <= 11'd0;
            pix_a    <= 12'h000;
            pix_b    <= 12'h000;
        end else begin
            if (start) begin
                hdr_add  <= TranAdd;
                hdr_frm  <= TranFrame;
                byte_idx <= 2'd1;
                pix_cnt  <= 6'd0;
                odd_pix  <= 1'b0;
                en_lost  <= 1'b0;
            end else if (push) begin
                byte_idx <= (state == ST_PACK && byte_idx == 2'd2) ? 2'd0 : byte_idx + 2'd1;
            end
            if (start || sample)  lat_cnt <= '0;
            else if (!lat_done)   lat_cnt <= lat_cnt + LAT_W'(1);
            if (sample) begin
                if (odd_pix) pix_b <= pix_val;
                else         pix_a <= pix_val;
                odd_pix <= !odd_pix;
                pix_cnt <= pix_cnt + 6'd1;
                if (!TranEn) en_lost <= 1'b1;
            end
            if (done_ok) begin
                seq     <= seq + 7'd1;
                pkt_cnt <= pkt_cnt + 11'd1;
            end
            if (start && TranFrame) begin
                seq     <= 7'd0;
                pkt_cnt <= 11'd0;
            end
        end
    end

    tx_byte_reg u_byte_reg (
        .Cclk      (Cclk),
        .rstn      (rstn),
        .in_valid  (push),
        .in_data   (push_data),
        .in_last   (push_last),
        .in_ready  (in_ready),
        .tx        (tx)
    );
endmodule

// File: tb/tb_tx_packetizer.sv
// tb/tb_tx_packetizer.sv - randomized bench for tx_packetizer against a packet-level model
`timescale 1ns/1ps
module tb_tx_packetizer;
    import tx_pkg::*;

    logic        Cclk = 1'b0, rstn = 1'b0, TranEn = 1'b0, TranFrame = 1'b0, tx_done = 1'b0;
    logic        NextData, busy;
    logic [11:0] TranData = 12'h000;
    logic [15:0] TranAdd = 16'h0000;
    logic [10:0] pkt_cnt;

    tx_packetizer_if tx_if();

    tx_packetizer dut (
        .Cclk(Cclk), .rstn(rstn), .TranEn(TranEn), .TranData(TranData), .TranFrame(TranFrame),
        .TranAdd(TranAdd), .NextData(NextData), .tx(tx_if), .tx_done(tx_done), .busy(busy),
        .pkt_cnt(pkt_cnt)
    );

    always #5 Cclk = ~Cclk;

    logic [11:0] mem [256];
    int          addr = 0, settle = 0, nd_cnt = 0, prot_err = 0, n_checks = 0, n_errors = 0, n;
    bit          nd_pend = 0, force_low = 0, last_seen = 0, prev_stall = 0, prev_last = 0;
    logic [7:0]  prev_data = 8'h00;
    logic [7:0]  rx_q[$];
    bit          rx_last_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge Cclk);
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_last_q.delete();
        last_seen = 0;
        nd_cnt = 0;
    endtask

    task automatic wait_last(input string tag);
        int k = 0;
        while (!last_seen && k < 3000) begin
            tick(); #2;
            k++;
        end
        chk({tag, "_tlast_seen"}, 32'(last_seen), 1);
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        #2;
    endtask

    // Expected packet from header fields and the memory contents; pixels past nreal are zero.
    task automatic check_pkt(input string tag, input bit frm, input int sq, input int add, input int nreal);
        logic [7:0] exp_q[$];
        int p0, p1, nlast, lastpos;
        nlast = 0;
        lastpos = -1;
        exp_q.push_back(8'(3 + PIX_PER_PKT * 3 / 2));
        exp_q.push_back(8'((frm ? 128 : 0) + (sq % 128)));
        exp_q.push_back(8'(add / 256));
        exp_q.push_back(8'(add % 256));
        for (int i = 0; i < PIX_PER_PKT; i += 2) begin
            p0 = (i < nreal) ? int'(mem[add + i]) : 0;
            p1 = (i + 1 < nreal) ? int'(mem[add + i + 1]) : 0;
            exp_q.push_back(8'(p0 / 16));
            exp_q.push_back(8'((p0 % 16) * 16 + p1 / 256));
            exp_q.push_back(8'(p1 % 256));
        end
        chk({tag, "_len"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), rx_q[i], exp_q[i]);
        foreach (rx_last_q[i]) if (rx_last_q[i]) begin nlast++; lastpos = i; end
        chk({tag, "_nlast"}, nlast, 1);
        chk({tag, "_lastpos"}, lastpos, exp_q.size() - 1);
    endtask

    // Memory stage model plus stream monitor; observations land 1 ns after the falling edge.
    initial begin
        tx_if.tready = 1'b0;
        forever begin
            @(negedge Cclk);
            if (nd_pend) begin
                addr++;
                nd_pend = 0;
                settle = DATA_LAT - 1;
                TranData = 12'($urandom);
            end else begin
                if (settle > 0) settle--;
                if (settle == 0) TranData = mem[addr];
            end
            TranAdd = 16'(addr);
            TranFrame = (addr == 0);
            tx_if.tready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
            #1;
            if (!rstn) begin
                prev_stall = 0;
            end else begin
                if (prev_stall && (!tx_if.tvalid || tx_if.tdata != prev_data || tx_if.tlast != prev_last))
                    prot_err++;
                if (NextData && tx_if.tvalid && !tx_if.tready) prot_err++;
                if (NextData) begin
                    nd_pend = 1;
                    nd_cnt++;
                end
                if (tx_if.tvalid && tx_if.tready) begin
                    rx_q.push_back(tx_if.tdata);
                    rx_last_q.push_back(tx_if.tlast);
                    if (tx_if.tlast) last_seen = 1;
                end
                prev_stall = tx_if.tvalid && !tx_if.tready;
                prev_data  = tx_if.tdata;
                prev_last  = tx_if.tlast;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (mem[i]) mem[i] = 12'($urandom);
        mem[0] = 12'hABC;
        mem[1] = 12'h123;
        repeat (3) tick();
        #2;
        chk("rst_tvalid", 32'(tx_if.tvalid), 0);
        chk("rst_tlast", 32'(tx_if.tlast), 0);
        chk("rst_tdata", 32'(tx_if.tdata), 0);
        chk("rst_nextdata", 32'(NextData), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pkt_cnt", 32'(pkt_cnt), 0);
        tick();
        rstn = 1'b1;
        repeat (2) tick();

        // Packet 1: frame start at address 0, with a forced stall inside the header
        clear_rx();
        TranEn = 1'b1;
        tick(); #2;
        chk("lat_tvalid", 32'(tx_if.tvalid), 1);
        chk("lat_tdata", 32'(tx_if.tdata), 32'h33);
        n = 0;
        while (rx_q.size() < 1 && n < 100) begin tick(); #2; n++; end
        force_low = 1;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick(); #2;
            chk($sformatf("stall_tvalid_%0d", i), 32'(tx_if.tvalid), 1);
            chk($sformatf("stall_tdata_%0d", i), 32'(tx_if.tdata), 32'h80);
        end
        force_low = 0;
        wait_last("p1");
        repeat (3) tick();
        check_pkt("p1", 1, 0, 0, 32);
        chk("p1_hdr1", 32'(rx_q[1]), 32'h80);
        chk("p1_pix0", 32'(rx_q[4]), 32'hAB);
        chk("p1_pix1", 32'(rx_q[5]), 32'hC1);
        chk("p1_pix2", 32'(rx_q[6]), 32'h23);
        chk("p1_nextdata", nd_cnt, 32);
        chk("p1_busy_wait", 32'(busy), 1);
        clear_rx();
        pulse_done();
        chk("p1_pkt_cnt", 32'(pkt_cnt), 1);

        // Packet 2 starts from tx_done while TranEn stays high
        wait_last("p2");
        tick();
        TranEn = 1'b0;
        repeat (2) tick();
        check_pkt("p2", 0, 1, 32, 32);
        chk("p2_hdr3", 32'(rx_q[3]), 32'h20);
        chk("p2_nextdata", nd_cnt, 32);
        pulse_done();
        chk("p2_pkt_cnt", 32'(pkt_cnt), 2);
        chk("p2_idle", 32'(busy), 0);

        // Packet 3: window closes after 10 pixels; stray tx_done mid-packet
        clear_rx();
        tick();
        TranEn = 1'b1;
        n = 0;
        while (nd_cnt < 10 && n < 2000) begin tick(); #2; n++; end
        tick();
        TranEn = 1'b0;
        pulse_done();
        wait_last("p3");
        repeat (3) tick();
        check_pkt("p3", 0, 2, 64, 10);
        chk("p3_nextdata", nd_cnt, 10);
        chk("p3_stray_done", 32'(pkt_cnt), 2);
        chk("p3_busy_wait", 32'(busy), 1);
        pulse_done();
        chk("p3_pkt_cnt", 32'(pkt_cnt), 3);
        chk("p3_idle", 32'(busy), 0);

        // Packet 4 aborted by reset mid-payload, then a clean restart
        clear_rx();
        tick();
        TranEn = 1'b1;
        n = 0;
        while (rx_q.size() < 12 && n < 2000) begin tick(); #2; n++; end
        tick();
        #3;
        rstn = 1'b0;
        TranEn = 1'b0;
        #1;
        chk("abort_tvalid", 32'(tx_if.tvalid), 0);
        chk("abort_tlast", 32'(tx_if.tlast), 0);
        chk("abort_tdata", 32'(tx_if.tdata), 0);
        chk("abort_nextdata", 32'(NextData), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_pkt_cnt", 32'(pkt_cnt), 0);
        tick(); #2;
        addr = 100;
        nd_pend = 0;
        settle = 0;
        clear_rx();
        tick();
        rstn = 1'b1;
        tick();
        TranEn = 1'b1;
        wait_last("p5");
        tick();
        TranEn = 1'b0;
        repeat (2) tick();
        check_pkt("p5", 0, 0, 100, 32);
        chk("p5_nextdata", nd_cnt, 32);
        pulse_done();
        chk("p5_pkt_cnt", 32'(pkt_cnt), 1);
        chk("protocol", prot_err, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
